// File: rtl/harmonic_telemetry_pkg.sv
// Shared types and constants for the harmonic telemetry capture engine.
package harmonic_telemetry_pkg;

  localparam int TAG_W = 2;
  localparam int TS_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FIFO,
    ST_ARMED,
    ST_POST,
    ST_DUMP
  } state_e;

  // A frame is one header word (tag + timestamp) followed by one word per channel.
  function automatic int frame_words(input int num_ch);
    return num_ch + 1;
  endfunction

endpackage

// File: rtl/telemetry_frame_ram.sv
// Simple dual-port frame store: one write port, one registered read port.
// The read register holds its value until the next read, so the top can
// serialize straight out of rdata without a separate frame buffer.
module telemetry_frame_ram #(
  parameter int DEPTH   = 256,
  parameter int FRAME_W = 108,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [FRAME_W-1:0] wdata,
  input  logic               re,
  input  logic [AW-1:0]      raddr,
  output logic [FRAME_W-1:0] rdata
);

  logic [FRAME_W-1:0] mem_q [DEPTH];
  logic [FRAME_W-1:0] rdata_q;

  // Write port and registered read port; contents are never reset.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/harmonic_telemetry_logger.sv
// Capture engine for per-harmonic telemetry: decimates the sample strobe,
// stores timestamped frames either as a FIFO or as a pre/post-trigger ring,
// and streams them out word by word over valid/ready.
module harmonic_telemetry_logger
  import harmonic_telemetry_pkg::*;
#(
  parameter int WIDTH   = 18,
  parameter int NUM_CH  = 5,
  parameter int DEPTH   = 256,
  parameter int POST    = 64,
  parameter int DECIM_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_en,
  input  logic [DECIM_W-1:0]      decim,
  input  logic                    mode,
  input  logic                    arm,
  input  logic                    trig_in,
  input  logic [1:0]              tag,
  input  logic [NUM_CH*WIDTH-1:0] ch_packed,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_sof,
  output logic                    out_eof,
  output logic                    busy,
  output logic [15:0]             drop_count
);

  localparam int NW      = frame_words(NUM_CH);
  localparam int FRAME_W = NW * WIDTH;
  localparam int AW      = $clog2(DEPTH);
  localparam int WC_W    = $clog2(NW);

  localparam logic [AW:0]     DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]     PRE_MIN = (AW+1)'(DEPTH - POST);
  localparam logic [AW:0]     POST_C  = (AW+1)'(POST);
  localparam logic [WC_W-1:0] LAST_W  = WC_W'(NW - 1);

  state_e              state_q, state_d;
  logic [DECIM_W-1:0]  decim_cnt_q, decim_cnt_d;
  logic [TS_W-1:0]     ts_q, ts_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [AW:0]         occ_q, occ_d;
  logic [AW:0]         unread_q, unread_d;
  logic [AW:0]         post_cnt_q, post_cnt_d;
  logic [AW:0]         dump_rem_q, dump_rem_d;
  logic [15:0]         drop_q, drop_d;
  logic                trig_q;
  logic                wr_en_q, wr_en_d;
  logic [AW-1:0]       wr_addr_q, wr_addr_d;
  logic [FRAME_W-1:0]  wr_data_q, wr_data_d;
  logic                frm_vld_q, frm_vld_d;
  logic [WC_W-1:0]     word_q, word_d;
  logic                out_valid_q, out_valid_d;
  logic [WIDTH-1:0]    out_data_q, out_data_d;
  logic                out_sof_q, out_sof_d;
  logic                out_eof_q, out_eof_d;

  logic                trig_rise, qual, store, drop, eof_pop;
  logic                can_read, load, last_load, rd_issue;
  logic [WIDTH-1:0]    word0, frame_word;
  logic [FRAME_W-1:0]  rdata;

  telemetry_frame_ram #(
    .DEPTH   (DEPTH),
    .FRAME_W (FRAME_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en_q),
    .waddr (wr_addr_q),
    .wdata (wr_data_q),
    .re    (rd_issue),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

  // Header word assembly and the word-select mux over the frame held in rdata.
  always_comb begin
    word0 = '0;
    word0[TS_W-1:0] = ts_q;
    word0[WIDTH-1 -: TAG_W] = tag;
    frame_word = '0;
    for (int w = 0; w < NW; w++) begin
      if (word_q == WC_W'(w)) frame_word = rdata[w*WIDTH +: WIDTH];
    end
  end

  // Next-state logic: decimator, capture, read issue, serializer and FSM.
  always_comb begin
    state_d     = state_q;
    decim_cnt_d = decim_cnt_q;
    ts_d        = ts_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occ_d       = occ_q;
    unread_d    = unread_q;
    post_cnt_d  = post_cnt_q;
    dump_rem_d  = dump_rem_q;
    drop_d      = drop_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    frm_vld_d   = frm_vld_q;
    word_d      = word_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sof_d   = out_sof_q;
    out_eof_d   = out_eof_q;
    store       = 1'b0;
    drop        = 1'b0;
    can_read    = 1'b0;

    trig_rise = trig_in & ~trig_q;
    qual      = sample_en && (decim_cnt_q == decim);
    eof_pop   = out_valid_q && out_ready && out_eof_q;

    if (sample_en) begin
      ts_d        = ts_q + 1'b1;
      decim_cnt_d = qual ? '0 : decim_cnt_q + 1'b1;
    end

    // A FIFO slot stays occupied until its eof word leaves, so a frame held
    // in the serializer still counts against capacity.
    case (state_q)
      ST_FIFO: begin
        if (qual) begin
          if (occ_q < DEPTH_C || eof_pop) store = 1'b1;
          else                            drop  = 1'b1;
        end
        can_read = (unread_q != '0);
      end
      ST_ARMED, ST_POST: store = qual;
      ST_DUMP:           can_read = (dump_rem_q != '0);
      default: ;
    endcase

    load      = frm_vld_q && (!out_valid_q || out_ready);
    last_load = load && (word_q == LAST_W);
    rd_issue  = can_read && (!frm_vld_q || last_load);

    if (store) begin
      wr_en_d   = 1'b1;
      wr_addr_d = wr_ptr_q;
      wr_data_d = {ch_packed, word0};
      wr_ptr_d  = wr_ptr_q + 1'b1;
    end

    if (drop && drop_q != 16'hFFFF) drop_d = drop_q + 1'b1;

    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = frame_word;
      out_sof_d   = (word_q == '0);
      out_eof_d   = (word_q == LAST_W);
      word_d      = last_load ? '0 : word_q + 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (rd_issue)       frm_vld_d = 1'b1;
    else if (last_load) frm_vld_d = 1'b0;

    case (state_q)
      ST_FIFO: begin
        occ_d    = occ_q + (AW+1)'(store) - (AW+1)'(eof_pop);
        unread_d = unread_q + (AW+1)'(wr_en_q) - (AW+1)'(rd_issue);
        if (rd_issue) rd_ptr_d = rd_ptr_q + 1'b1;
      end
      ST_ARMED: begin
        if (store && occ_q != DEPTH_C) occ_d = occ_q + 1'b1;
        if (trig_rise && occ_q >= PRE_MIN) begin
          state_d    = ST_POST;
          post_cnt_d = '0;
        end
      end
      ST_POST: begin
        // The ring is full here, so the slot after the newest is the oldest.
        if (store) begin
          if (post_cnt_q == POST_C - 1'b1) begin
            state_d    = ST_DUMP;
            rd_ptr_d   = wr_ptr_q + 1'b1;
            dump_rem_d = DEPTH_C;
          end else begin
            post_cnt_d = post_cnt_q + 1'b1;
          end
        end
      end
      ST_DUMP: begin
        if (rd_issue) begin
          rd_ptr_d   = rd_ptr_q + 1'b1;
          dump_rem_d = dump_rem_q - 1'b1;
        end
        if (dump_rem_q == '0 && !frm_vld_q && (!out_valid_q || out_ready))
          state_d = ST_IDLE;
      end
      default: ;
    endcase

    // arm restarts everything and abandons any word in flight.
    if (arm) begin
      state_d     = mode ? ST_ARMED : ST_FIFO;
      decim_cnt_d = '0;
      ts_d        = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      occ_d       = '0;
      unread_d    = '0;
      post_cnt_d  = '0;
      dump_rem_d  = '0;
      drop_d      = '0;
      wr_en_d     = 1'b0;
      frm_vld_d   = 1'b0;
      word_d      = '0;
      out_valid_d = 1'b0;
      out_data_d  = '0;
      out_sof_d   = 1'b0;
      out_eof_d   = 1'b0;
    end
  end

  // Control state and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      decim_cnt_q <= '0;
      ts_q        <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      unread_q    <= '0;
      post_cnt_q  <= '0;
      dump_rem_q  <= '0;
      drop_q      <= '0;
      trig_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      frm_vld_q   <= 1'b0;
      word_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sof_q   <= 1'b0;
      out_eof_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      decim_cnt_q <= decim_cnt_d;
      ts_q        <= ts_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      unread_q    <= unread_d;
      post_cnt_q  <= post_cnt_d;
      dump_rem_q  <= dump_rem_d;
      drop_q      <= drop_d;
      trig_q      <= trig_in;
      wr_en_q     <= wr_en_d;
      frm_vld_q   <= frm_vld_d;
      word_q      <= word_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sof_q   <= out_sof_d;
      out_eof_q   <= out_eof_d;
    end
  end

  // Capture stage boundary: frame and address registered, written to RAM next cycle.
  always_ff @(posedge clk) begin
    wr_addr_q <= wr_addr_d;
    wr_data_q <= wr_data_d;
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_sof    = out_sof_q;
  assign out_eof    = out_eof_q;
  assign busy       = (state_q != ST_IDLE);
  assign drop_count = drop_q;

endmodule

// File: tb/tb_harmonic_telemetry_logger.sv
// Scoreboard bench for harmonic_telemetry_logger: stimulus pushes expected
// stream words, a negedge monitor pops and compares on every transfer.
module tb_harmonic_telemetry_logger;

  localparam int WIDTH   = 18;
  localparam int NUM_CH  = 5;
  localparam int DEPTH   = 256;
  localparam int POST    = 64;
  localparam int DECIM_W = 8;
  localparam int NW      = NUM_CH + 1;

  typedef logic [WIDTH+1:0] ent_t;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    sample_en = 1'b0;
  logic [DECIM_W-1:0]      decim = '0;
  logic                    mode = 1'b0;
  logic                    arm = 1'b0;
  logic                    trig_in = 1'b0;
  logic [1:0]              tag = '0;
  logic [NUM_CH*WIDTH-1:0] ch_packed = '0;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_sof;
  logic                    out_eof;
  logic                    busy;
  logic [15:0]             drop_count;

  logic rand_mode = 1'b0;
  logic ready_fix = 1'b1;
  int   chk_cnt = 0;
  int   err_cnt = 0;
  int   tb_ts = 0;
  ent_t exp_q[$];

  harmonic_telemetry_logger #(
    .WIDTH   (WIDTH),
    .NUM_CH  (NUM_CH),
    .DEPTH   (DEPTH),
    .POST    (POST),
    .DECIM_W (DECIM_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sample_en  (sample_en),
    .decim      (decim),
    .mode       (mode),
    .arm        (arm),
    .trig_in    (trig_in),
    .tag        (tag),
    .ch_packed  (ch_packed),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sof    (out_sof),
    .out_eof    (out_eof),
    .busy       (busy),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  // Sink: fixed or random ready, updated just after each rising edge.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_fix;
    end
  end

  // Monitor: compare each transferred word, and check fields hold while stalled.
  initial begin
    logic stalled;
    logic kill;
    ent_t held;
    ent_t got;
    ent_t e;
    stalled = 1'b0;
    kill    = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      got = {out_sof, out_eof, out_data};
      if (stalled && !kill) begin
        chk_cnt++;
        if (!out_valid || got !== held) begin
          err_cnt++;
          $display("FAIL stall_hold: got v=%0b word=%0h required v=1 word=%0h", out_valid, got, held);
        end
      end
      if (out_valid && out_ready) begin
        chk_cnt++;
        if (exp_q.size() == 0) begin
          err_cnt++;
          $display("FAIL unexpected_word: got %0h with no word expected", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            err_cnt++;
            $display("FAIL stream_word: got sof/eof/data %0h required %0h", got, e);
          end
        end
      end
      stalled = out_valid && !out_ready;
      held    = got;
      kill    = arm || rst;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    chk_cnt++;
    if (act !== req) begin
      err_cnt++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic push_frame(input int t);
    logic [WIDTH-1:0] w;
    logic [31:0]      tv;
    tv = 32'(t);
    w = '0;
    w[15:0] = tv[15:0];
    w[WIDTH-1 -: 2] = tv[1:0];
    exp_q.push_back({1'b1, 1'b0, w});
    for (int k = 0; k < NUM_CH; k++)
      exp_q.push_back({1'b0, (k == NUM_CH - 1), WIDTH'(100 * t + k)});
  endtask

  task automatic sample(input int gap);
    logic [31:0] tv;
    tv = 32'(tb_ts);
    tag = tv[1:0];
    for (int k = 0; k < NUM_CH; k++)
      ch_packed[k*WIDTH +: WIDTH] = WIDTH'(100 * tb_ts + k);
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
    tb_ts++;
    repeat (gap) tick();
  endtask

  task automatic do_arm(input logic m);
    mode = m;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    tb_ts = 0;
  endtask

  task automatic drain(input int limit, input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      tick();
      n++;
    end
    check({name, "_drained_left"}, 32'(exp_q.size()), 32'd0);
    repeat (3) tick();
    check({name, "_valid_after"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int dc;
    // Reset values
    repeat (3) tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_sof", 32'(out_sof), 32'd0);
    check("rst_eof", 32'(out_eof), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_drop", 32'(drop_count), 32'd0);
    rst = 1'b0;
    tick();
    check("idle_busy", 32'(busy), 32'd0);

    // Continuous, decim=0: 10 frames, timestamps 0..9
    decim = '0;
    do_arm(1'b0);
    check("fifo_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 10; i++) begin
      push_frame(tb_ts);
      sample(7);
    end
    drain(300, "cont");
    check("cont_drop", 32'(drop_count), 32'd0);

    // Decimation by 4: timestamps 3,7,...,39
    decim = 8'd3;
    do_arm(1'b0);
    dc = 0;
    for (int i = 0; i < 40; i++) begin
      if (dc == 3) begin
        push_frame(tb_ts);
        dc = 0;
      end else begin
        dc++;
      end
      sample(3);
    end
    drain(300, "decim");

    // Full FIFO under stall: DEPTH stored, 5 dropped
    decim = '0;
    ready_fix = 1'b0;
    tick();
    tick();
    do_arm(1'b0);
    for (int i = 0; i < DEPTH + 5; i++) begin
      if (i < DEPTH) push_frame(tb_ts);
      sample(0);
    end
    repeat (5) tick();
    check("full_drop", 32'(drop_count), 32'd5);
    ready_fix = 1'b1;
    drain(DEPTH * NW + 200, "full");
    check("full_drop_hold", 32'(drop_count), 32'd5);

    // Triggered snapshot: 300 pre samples, trigger, 64 post -> stamps 108..363
    do_arm(1'b1);
    check("armed_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 300; i++) sample(1);
    trig_in = 1'b1;
    tick();
    for (int t = 108; t < 364; t++) push_frame(t);
    for (int i = 0; i < POST; i++) sample(1);
    trig_in = 1'b0;
    check("dump_busy", 32'(busy), 32'd1);
    drain(DEPTH * NW + 200, "trig");
    check("trig_busy_done", 32'(busy), 32'd0);

    // Early edge after 50 frames ignored; edge after 200 frames accepted -> 8..263
    do_arm(1'b1);
    for (int i = 0; i < 50; i++) sample(1);
    trig_in = 1'b1;
    tick();
    trig_in = 1'b0;
    tick();
    check("early_ignored_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 150; i++) sample(1);
    trig_in = 1'b1;
    tick();
    for (int t = 8; t < 264; t++) push_frame(t);
    for (int i = 0; i < POST; i++) sample(1);
    trig_in = 1'b0;
    drain(DEPTH * NW + 200, "late_trig");
    check("late_busy_done", 32'(busy), 32'd0);

    // Same capture drained under random backpressure
    rand_mode = 1'b1;
    do_arm(1'b1);
    for (int i = 0; i < 200; i++) sample(1);
    trig_in = 1'b1;
    tick();
    for (int t = 8; t < 264; t++) push_frame(t);
    for (int i = 0; i < POST; i++) sample(1);
    trig_in = 1'b0;
    drain(DEPTH * NW * 4 + 400, "bp");
    rand_mode = 1'b0;
    check("bp_busy_done", 32'(busy), 32'd0);

    // Reset in the middle of a dump
    do_arm(1'b1);
    for (int i = 0; i < 256; i++) sample(0);
    trig_in = 1'b1;
    tick();
    for (int t = 64; t < 320; t++) push_frame(t);
    for (int i = 0; i < POST; i++) sample(0);
    trig_in = 1'b0;
    repeat (60) tick();
    check("mid_dump_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    check("mdrst_valid", 32'(out_valid), 32'd0);
    check("mdrst_sof", 32'(out_sof), 32'd0);
    check("mdrst_eof", 32'(out_eof), 32'd0);
    check("mdrst_data", 32'(out_data), 32'd0);
    check("mdrst_busy", 32'(busy), 32'd0);
    check("mdrst_drop", 32'(drop_count), 32'd0);
    rst = 1'b0;
    exp_q.delete();
    repeat (5) tick();
    check("post_rst_valid", 32'(out_valid), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/harmonic_telemetry_logger.md
# harmonic_telemetry_logger

On-chip, synthesizable capture engine for per-harmonic coherence and gain telemetry. It replaces simulation-only CSV dumps with a buffered hardware stream. It sits beside the thalamic SR harmonic bank and samples a packed NUM_CH-channel vector on the 4 kHz update strobe, with programmable decimation. Frames are stored either as a continuous FIFO or as a pre/post-trigger snapshot around SIE events, then emitted as a valid/ready word stream toward the host link.

## Interface
Parameters:
- WIDTH, 18, channel word width (≥18)
- NUM_CH, 5, channels per frame (coherence/gain per harmonic)
- DEPTH, 256, frame slots (power of two)
- POST, 64, frames captured after trigger (< DEPTH)
- DECIM_W, 8, decimation field width

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock, synchronous, active-high
- sample_en  in  1  4 kHz update strobe, one-cycle pulse
- decim  in  DECIM_W  store every (decim+1)th sample_en
- mode  in  1  0 = continuous FIFO, 1 = triggered snapshot
- arm  in  1  pulse: clear buffer/counters, start capture
- trig_in  in  1  level; rising edge triggers (e.g. OR of sie_per_harmonic)
- tag  in  2  phase/state tag stored with each frame
- ch_packed  in  NUM_CH*WIDTH  channel k at [k*WIDTH +: WIDTH]
- out_valid  out  1  stream word valid
- out_ready  in  1  sink accepts word
- out_data  out  WIDTH  stream word
- out_sof / out_eof  out  1  first / last word of a frame
- busy  out  1  state ≠ IDLE
- drop_count  out  16  frames dropped on full, saturating

## Operation
- States: IDLE, FIFO (mode 0), ARMED, POST, DUMP (mode 1).
- IDLE: no writes. arm with mode=0 → FIFO; arm with mode=1 → ARMED. arm in any state restarts: pointers, occupancy, timestamp, decimation counter, drop_count cleared; stream word in flight is abandoned.
- Decimation: counter increments on each sample_en; a frame is stored when counter == decim, then counter → 0. decim=0 stores every pulse.
- Timestamp: 16-bit count of sample_en since arm; wraps modulo 2^16.
- Frame layout: word0 = {tag, timestamp zero-extended to WIDTH-2}; words 1..NUM_CH = channels 0..NUM_CH-1. Frame = NUM_CH+1 words.
- FIFO: store on qualified sample; read out concurrently. Store while full is discarded and drop_count increments, saturating at 0xFFFF. Simultaneous store and frame-pop on the last free slot succeeds.
- ARMED: circular writes overwrite the oldest frame. trig_in rising edge is accepted only once ≥ DEPTH-POST frames are stored; earlier edges are ignored. Accepted edge → POST.
- POST: store exactly POST more frames, then → DUMP. Buffer is frozen.
- DUMP: emit all DEPTH frames oldest-first, then → IDLE. trig_in is ignored.

## Timing
- Reset values: out_valid=0, out_sof=0, out_eof=0, out_data=0, busy=0, drop_count=0, state=IDLE.
- Capture: qualifying sample_en at cycle N → RAM write at N+1. The frame is readable from N+2.
- Readout: 1-cycle RAM read plus registered output. The first word is valid no earlier than 2 cycles after the frame becomes available.
- Handshake: a word transfers on out_valid & out_ready. out_data/out_sof/out_eof are held stable while out_valid & !out_ready. out_valid never drops without a transfer, except on rst or arm.
- With out_ready tied high, throughput is 1 word/clk. A frame takes NUM_CH+1 cycles, far below the sample_en rate.
- arm and sample_en in the same cycle: arm wins; that sample is not stored and the timestamp starts at 0.

## Structure
- Package harmonic_telemetry_pkg: state enum, frame word-count function, tag width, timestamp width.
- One sub-module, telemetry_frame_ram: simple dual-port RAM, DEPTH × ((NUM_CH+1)*WIDTH), registered read.
- Top module: control FSM, pointers, decimator, and word serializer (mux indexed by a word counter).

## Test plan
- Continuous, decim=0, out_ready=1, ch_packed ramp: 10 sample_en → 10 frames, timestamps 0..9, channel k of frame i = 100*i+k, sof/eof on words 0/5.
- Decimation: decim=3, 40 sample_en → 10 frames with timestamps 3,7,…,39.
- Full: out_ready=0, DEPTH+5 qualified samples → drop_count=5. Then out_ready=1 → exactly DEPTH frames drained, out_valid then 0.
- Triggered, DEPTH=256, POST=64, 300 samples then trig_in rise → DUMP of 256 frames. The first-frame timestamp equals the trigger-sample stamp minus 191; busy drops after the last eof.
- Early trigger (after 50 frames) ignored; a later edge (after 200 frames) is accepted.
- Backpressure: random out_ready → stream data identical to the out_ready=1 run, and no field changes while stalled. rst mid-DUMP → all outputs return to reset values the next cycle.
